d26_responder: RTL

- Target-side responder for the go/get/put/kill/endtx transaction protocol. The initiator drives those five signals; this block services them.
- Opens a transaction on go and stores put data in a small FIFO. Returns data on get.
- Closes the transaction on endtx; aborts and flushes on kill or on an inactivity timeout.
- Reports status pulses and protocol errors so the initiator side and the SVA checkers can be exercised against a live target.

---
 rtl/d26_resp_pkg.sv | 19 +
 rtl/d26_resp_fifo.sv | 65 ++++++
 rtl/d26_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/d26_resp_pkg.sv
// Shared types and sizing helpers for the d26 responder.
// State encoding plus the FIFO occupancy width rule.
package d26_resp_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_DW      = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 16;

    // occupancy needs one extra bit so full and empty differ
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/d26_resp_fifo.sv
// Small synchronous FIFO with registered read data.
// Push and pop in the same cycle are legal even when full.
module d26_resp_fifo
    import d26_resp_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          wdata,
    output logic [DW-1:0]          rdata,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    // pointers, occupancy and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdata <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rdata <= mem[rptr];
                rptr  <= rptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/d26_responder.sv
// Target-side responder for the go/get/put/kill/endtx protocol.
// Holds the FSM, inactivity timer and status pulses around the FIFO.
module d26_responder
    import d26_resp_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic                    get,
    input  logic                    put,
    input  logic                    kill,
    input  logic                    endtx,
    input  logic [DW-1:0]           wdata,
    output logic [DW-1:0]           rdata,
    output logic                    rvalid,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    err,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic          flush;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          err_n;
    logic          done_n;
    logic          abort_n;
    logic          rvalid_n;
    logic          act;

    assign act  = get | put | endtx;
    assign busy = (state == ACTIVE);

    d26_resp_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // state, timer and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            rvalid  <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            rvalid  <= rvalid_n;
            done    <= done_n;
            aborted <= abort_n;
            err     <= err_n;
        end
    end

    // next-state, beat decode and pulse generation
    always_comb begin
        state_n  = state;
        tcnt_n   = '0;
        flush    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        err_n    = 1'b0;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        rvalid_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (go) begin
                    state_n = ACTIVE;
                end else if (act) begin
                    err_n = 1'b1;
                end
            end
            ACTIVE: begin
                if (kill) begin
                    flush   = 1'b1;
                    abort_n = 1'b1;
                    state_n = IDLE;
                end else if (!act && tcnt == TW'(TIMEOUT - 1)) begin
                    // inactivity limit reached: abort and flag it
                    flush   = 1'b1;
                    abort_n = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tcnt_n   = act ? '0 : tcnt + 1'b1;
                    pop      = get & ~empty;
                    push     = put & (~full | (get & ~empty));
                    rvalid_n = get & ~empty;
                    err_n    = go | (get & empty)
                             | (put & full & ~get);
                    if (endtx) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
